// File: rtl/cache_pkg.sv
// Shared types and address-field constants for the 2-way write-through data cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int LINE_W = 64;
    localparam int WORD_W = 32;

    localparam int DEF_SET_BITS = 6;
    localparam int DEF_TAG_W    = 10;
    localparam int DEF_SRAM_AW  = 18;

    // Fixed low address fields: byte lane [1:0], word-in-line [2], index from [3].
    localparam int OFFSET_BIT = 2;
    localparam int INDEX_LSB  = 3;
    localparam int TAG_LSB    = INDEX_LSB + DEF_SET_BITS;
    localparam int TAG_MSB    = TAG_LSB + DEF_TAG_W - 1;

endpackage

// File: rtl/cache_array.sv
// Valid/tag/data/LRU storage for a 2-way set-associative cache with a
// combinational lookup and a single fill / word-update write port.
module cache_array
    import cache_pkg::*;
#(
    parameter int SET_BITS = DEF_SET_BITS,
    parameter int TAG_W    = DEF_TAG_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SET_BITS-1:0] idx,
    input  logic [TAG_W-1:0]    tag,
    input  logic                offset,
    output logic                hit,
    output logic                hit_way,
    output logic [WORD_W-1:0]   hit_word,
    output logic                victim_way,
    input  logic                fill_en,
    input  logic [LINE_W-1:0]   fill_line,
    input  logic                word_en,
    input  logic [WORD_W-1:0]   word_data,
    input  logic                touch_en,
    input  logic                way
);
    localparam int SETS = 1 << SET_BITS;

    logic [SETS-1:0]   valid_q [2];
    logic [SETS-1:0]   lru_q;
    logic [TAG_W-1:0]  tag_mem [2][SETS];
    logic [LINE_W-1:0] data_mem [2][SETS];

    logic              hit0, hit1;
    logic [LINE_W-1:0] line_sel;

    assign hit0       = valid_q[0][idx] && (tag_mem[0][idx] == tag);
    assign hit1       = valid_q[1][idx] && (tag_mem[1][idx] == tag);
    assign hit        = hit0 || hit1;
    assign hit_way    = hit1;
    assign line_sel   = hit1 ? data_mem[1][idx] : data_mem[0][idx];
    assign hit_word   = offset ? line_sel[LINE_W-1:WORD_W] : line_sel[WORD_W-1:0];
    // Free ways are used before anything is evicted; way0 wins when both are free.
    assign victim_way = !valid_q[0][idx] ? 1'b0 :
                        !valid_q[1][idx] ? 1'b1 : lru_q[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            if (fill_en)
                valid_q[way][idx] <= 1'b1;
            if (touch_en)
                lru_q[idx] <= ~way;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[way][idx]  <= tag;
            data_mem[way][idx] <= fill_line;
        end else if (word_en) begin
            if (offset)
                data_mem[way][idx][LINE_W-1:WORD_W] <= word_data;
            else
                data_mem[way][idx][WORD_W-1:0] <= word_data;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// 2-way write-through, read-allocate data cache in front of sram_controller.
// Optional hit/miss counters are built when CACHE_PERF_CNT_EN is defined.
//   state | meaning
//   IDLE  | serve read hits, accept new requests
//   FILL  | line fill from SRAM in flight
//   WRITE | word write-through to SRAM in flight
module cache_controller
    import cache_pkg::*;
#(
    parameter int SET_BITS = DEF_SET_BITS,
    parameter int TAG_W    = DEF_TAG_W,
    parameter int SRAM_AW  = DEF_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic               sram_rd_en,
    output logic               sram_wr_en,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [63:0]        sram_rdata,
    input  logic               sram_ready
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
`endif
);
    localparam int TAG_LO = INDEX_LSB + SET_BITS;
    localparam int TAG_HI = TAG_LO + TAG_W - 1;

    state_t              state_q, state_d;
    logic [SET_BITS-1:0] idx;
    logic [TAG_W-1:0]    tag;
    logic                offset;
    logic                hit, hit_way, victim_way;
    logic [WORD_W-1:0]   hit_word;
    logic                fill_en, word_en, touch_en, upd_way;
    logic                unused_addr;

    assign idx         = addr[TAG_LO-1:INDEX_LSB];
    assign tag         = addr[TAG_HI:TAG_LO];
    assign offset      = addr[OFFSET_BIT];
    assign unused_addr = ^{addr[31:TAG_HI+1], addr[1:0]};

    cache_array #(
        .SET_BITS (SET_BITS),
        .TAG_W    (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx),
        .tag        (tag),
        .offset     (offset),
        .hit        (hit),
        .hit_way    (hit_way),
        .hit_word   (hit_word),
        .victim_way (victim_way),
        .fill_en    (fill_en),
        .fill_line  (sram_rdata),
        .word_en    (word_en),
        .word_data  (wdata),
        .touch_en   (touch_en),
        .way        (upd_way)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Enables are decoded from state so a reset drops them without waiting for a clock.
    always_comb begin
        state_d    = state_q;
        ready      = 1'b1;
        rdata      = '0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        fill_en    = 1'b0;
        word_en    = 1'b0;
        touch_en   = 1'b0;
        upd_way    = hit_way;
        unique case (state_q)
            IDLE: begin
                if (wr_en) begin
                    state_d = WRITE;
                    ready   = 1'b0;
                end else if (rd_en) begin
                    if (hit) begin
                        rdata    = hit_word;
                        touch_en = 1'b1;
                    end else begin
                        state_d = FILL;
                        ready   = 1'b0;
                    end
                end
            end
            FILL: begin
                sram_rd_en = 1'b1;
                sram_addr  = {addr[SRAM_AW:3], 2'b00};
                ready      = 1'b0;
                if (sram_ready) begin
                    fill_en  = 1'b1;
                    touch_en = 1'b1;
                    upd_way  = victim_way;
                    rdata    = offset ? sram_rdata[LINE_W-1:WORD_W] : sram_rdata[WORD_W-1:0];
                    ready    = 1'b1;
                    state_d  = IDLE;
                end
            end
            WRITE: begin
                sram_wr_en = 1'b1;
                sram_addr  = {addr[SRAM_AW:2], 1'b0};
                sram_wdata = wdata;
                ready      = 1'b0;
                if (sram_ready) begin
                    word_en  = hit;
                    touch_en = hit;
                    ready    = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (state_q == IDLE && !wr_en && rd_en && hit)
                hit_cnt <= hit_cnt + 32'd1;
            if (state_q == FILL && sram_ready)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios plus randomized
// traffic checked against a recency-list / flat-memory reference model.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] addr, wdata, rdata;
    logic        ready;
    logic        sram_rd_en, sram_wr_en;
    logic [17:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_rd_en (sram_rd_en),
        .sram_wr_en (sram_wr_en),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ready (sram_ready)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    // SRAM controller model: ready when idle, otherwise after 6 enabled cycles (count 0..5).
    logic [63:0] sram_mem [65536];
    logic [2:0]  sram_cnt;

    assign sram_ready = !(sram_rd_en || sram_wr_en) || (sram_cnt == 3'd5);
    assign sram_rdata = sram_mem[sram_addr[17:2]];

    always @(posedge clk or posedge rst) begin
        if (rst)
            sram_cnt <= 3'd0;
        else if ((sram_rd_en || sram_wr_en) && sram_cnt != 3'd5)
            sram_cnt <= sram_cnt + 3'd1;
        else
            sram_cnt <= 3'd0;
    end

    always @(posedge clk) begin
        if (!rst && sram_wr_en && sram_ready) begin
            if (sram_addr[1])
                sram_mem[sram_addr[17:2]][63:32] <= sram_wdata;
            else
                sram_mem[sram_addr[17:2]][31:0] <= sram_wdata;
        end
    end

    // Reference: flat memory image plus, per set, the resident tags in recency order.
    logic [63:0] ref_mem [65536];
    logic [9:0]  mru_tag [64];
    logic [9:0]  lru_tag [64];
    int          n_res   [64];
    int          ref_hits, ref_misses;

    function automatic logic [63:0] init_line(int i);
        logic [31:0] u;
        u = i;
        return {u * 32'h9E37_79B1, ~(u * 32'h85EB_CA6B)};
    endfunction

    function automatic bit ref_is_hit(logic [31:0] a);
        int  s;
        s = int'(a[8:3]);
        return (n_res[s] >= 1 && mru_tag[s] == a[18:9]) ||
               (n_res[s] == 2 && lru_tag[s] == a[18:9]);
    endfunction

    task automatic ref_touch(logic [31:0] a);
        int s;
        s = int'(a[8:3]);
        if (mru_tag[s] != a[18:9]) begin
            lru_tag[s] = mru_tag[s];
            mru_tag[s] = a[18:9];
        end
    endtask

    task automatic ref_read(input logic [31:0] a, output logic [31:0] exp, output bit h);
        int s;
        s = int'(a[8:3]);
        h = ref_is_hit(a);
        if (h) begin
            ref_touch(a);
            ref_hits++;
        end else begin
            if (n_res[s] >= 1) lru_tag[s] = mru_tag[s];
            mru_tag[s] = a[18:9];
            if (n_res[s] < 2) n_res[s]++;
            ref_misses++;
        end
        exp = a[2] ? ref_mem[a[18:3]][63:32] : ref_mem[a[18:3]][31:0];
    endtask

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
        if (ref_is_hit(a)) ref_touch(a);
        if (a[2]) ref_mem[a[18:3]][63:32] = d;
        else      ref_mem[a[18:3]][31:0]  = d;
    endtask

    task automatic ref_reset();
        for (int s = 0; s < 64; s++) n_res[s] = 0;
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    // One MEM-stage request held until ready; reports what was seen on the SRAM side.
    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int low, output bit rd_seen,
                          output bit wr_seen, output logic [17:0] sa, output logic [31:0] swd);
        @(negedge clk);
        rd_en = !wr; wr_en = wr; addr = a; wdata = d;
        low = 0; rd_seen = 0; wr_seen = 0; sa = '0; swd = '0;
        #2;
        while (!ready && low <= 40) begin
            if (sram_rd_en) rd_seen = 1;
            if (sram_wr_en) wr_seen = 1;
            if (sram_rd_en || sram_wr_en) begin sa = sram_addr; swd = sram_wdata; end
            low++;
            @(negedge clk); #2;
        end
        if (sram_rd_en) rd_seen = 1;
        if (sram_wr_en) wr_seen = 1;
        if (sram_rd_en || sram_wr_en) begin sa = sram_addr; swd = sram_wdata; end
        rd = rdata;
        @(posedge clk); #1;
        rd_en = 0; wr_en = 0;
    endtask

    task automatic check_counters(string name);
`ifdef CACHE_PERF_CNT_EN
        n_cmp++;
        if (hit_cnt !== ref_hits) begin
            n_bad++; $display("FAIL %s hit_cnt: got %0d expected %0d", name, hit_cnt, ref_hits);
        end
        n_cmp++;
        if (miss_cnt !== ref_misses) begin
            n_bad++; $display("FAIL %s miss_cnt: got %0d expected %0d", name, miss_cnt, ref_misses);
        end
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    task automatic test_reset();
        rst = 1; rd_en = 0; wr_en = 0; addr = '0; wdata = '0;
        ref_reset();
        repeat (2) @(posedge clk);
        #2;
        n_cmp++; if (ready !== 1'b1)      begin n_bad++; $display("FAIL reset ready: got %b expected 1", ready); end
        n_cmp++; if (sram_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset sram_rd_en: got %b expected 0", sram_rd_en); end
        n_cmp++; if (sram_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset sram_wr_en: got %b expected 0", sram_wr_en); end
        n_cmp++; if (sram_addr !== 18'h0) begin n_bad++; $display("FAIL reset sram_addr: got %h expected 0", sram_addr); end
        n_cmp++; if (sram_wdata !== 32'h0) begin n_bad++; $display("FAIL reset sram_wdata: got %h expected 0", sram_wdata); end
        n_cmp++; if (rdata !== 32'h0)     begin n_bad++; $display("FAIL reset rdata: got %h expected 0", rdata); end
        check_counters("reset");
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_cold_fill();
        logic [31:0] rd, exp; int low; bit rs, ws, h; logic [17:0] sa; logic [31:0] swd;
        access(0, 32'h0000_0404, 32'h0, rd, low, rs, ws, sa, swd);
        ref_read(32'h0000_0404, exp, h);
        n_cmp++; if (low !== 6)       begin n_bad++; $display("FAIL cold_fill ready_low: got %0d expected 6", low); end
        n_cmp++; if (rs !== 1'b1)     begin n_bad++; $display("FAIL cold_fill sram_rd_en: got %b expected 1", rs); end
        n_cmp++; if (sa !== 18'h200)  begin n_bad++; $display("FAIL cold_fill sram_addr: got %h expected 200", sa); end
        n_cmp++; if (rd !== exp)      begin n_bad++; $display("FAIL cold_fill rdata: got %h expected %h", rd, exp); end
        @(negedge clk); #2;
        n_cmp++; if (sram_rd_en !== 1'b0) begin n_bad++; $display("FAIL fill_drop sram_rd_en: got %b expected 0", sram_rd_en); end
        access(0, 32'h0000_0400, 32'h0, rd, low, rs, ws, sa, swd);
        ref_read(32'h0000_0400, exp, h);
        n_cmp++; if (low !== 0)       begin n_bad++; $display("FAIL rehit ready_low: got %0d expected 0", low); end
        n_cmp++; if (rs !== 1'b0)     begin n_bad++; $display("FAIL rehit sram_rd_en: got %b expected 0", rs); end
        n_cmp++; if (rd !== exp)      begin n_bad++; $display("FAIL rehit rdata: got %h expected %h", rd, exp); end
        check_counters("cold_fill");
    endtask

    task automatic test_lru_evict();
        logic [31:0] seq [6] = '{32'h428, 32'hA28, 32'h428, 32'h1028, 32'h428, 32'hA28};
        int          want [6] = '{6, 6, 0, 6, 0, 6};
        logic [31:0] rd, exp; int low; bit rs, ws, h; logic [17:0] sa; logic [31:0] swd;
        for (int i = 0; i < 6; i++) begin
            access(0, seq[i], 32'h0, rd, low, rs, ws, sa, swd);
            ref_read(seq[i], exp, h);
            n_cmp++; if (low !== want[i]) begin n_bad++; $display("FAIL lru step%0d ready_low: got %0d expected %0d", i, low, want[i]); end
            n_cmp++; if (rd !== exp)      begin n_bad++; $display("FAIL lru step%0d rdata: got %h expected %h", i, rd, exp); end
        end
        check_counters("lru_evict");
    endtask

    task automatic test_write_hit();
        logic [31:0] rd, exp; int low; bit rs, ws, h; logic [17:0] sa; logic [31:0] swd;
        access(1, 32'h0000_0404, 32'hDEAD_BEEF, rd, low, rs, ws, sa, swd);
        ref_write(32'h0000_0404, 32'hDEAD_BEEF);
        n_cmp++; if (low !== 6)             begin n_bad++; $display("FAIL wr_hit ready_low: got %0d expected 6", low); end
        n_cmp++; if (ws !== 1'b1)           begin n_bad++; $display("FAIL wr_hit sram_wr_en: got %b expected 1", ws); end
        n_cmp++; if (sa !== 18'h202)        begin n_bad++; $display("FAIL wr_hit sram_addr: got %h expected 202", sa); end
        n_cmp++; if (swd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_hit sram_wdata: got %h expected deadbeef", swd); end
        access(0, 32'h0000_0404, 32'h0, rd, low, rs, ws, sa, swd);
        ref_read(32'h0000_0404, exp, h);
        n_cmp++; if (low !== 0)             begin n_bad++; $display("FAIL wr_hit reread ready_low: got %0d expected 0", low); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF)  begin n_bad++; $display("FAIL wr_hit reread rdata: got %h expected deadbeef", rd); end
        check_counters("write_hit");
    endtask

    task automatic test_write_miss();
        logic [31:0] rd, exp, d; int low; bit rs, ws, h; logic [17:0] sa; logic [31:0] swd;
        d = $urandom;
        access(1, 32'h0000_8000, d, rd, low, rs, ws, sa, swd);
        ref_write(32'h0000_8000, d);
        n_cmp++; if (ws !== 1'b1)     begin n_bad++; $display("FAIL wr_miss sram_wr_en: got %b expected 1", ws); end
        n_cmp++; if (sa !== 18'h4000) begin n_bad++; $display("FAIL wr_miss sram_addr: got %h expected 4000", sa); end
        n_cmp++; if (swd !== d)       begin n_bad++; $display("FAIL wr_miss sram_wdata: got %h expected %h", swd, d); end
        access(0, 32'h0000_8000, 32'h0, rd, low, rs, ws, sa, swd);
        ref_read(32'h0000_8000, exp, h);
        n_cmp++; if (low !== 6)       begin n_bad++; $display("FAIL wr_miss reread ready_low: got %0d expected 6", low); end
        n_cmp++; if (rd !== exp)      begin n_bad++; $display("FAIL wr_miss reread rdata: got %h expected %h", rd, exp); end
        check_counters("write_miss");
    endtask

    task automatic test_random();
        int          sets [4] = '{0, 5, 9, 63};
        logic [31:0] a, d, rd, exp; int low, want; bit wr, rs, ws, h; logic [17:0] sa; logic [31:0] swd;
        for (int i = 0; i < 300; i++) begin
            a = {$urandom_range(8191, 0) & 32'h1FFF, 19'h0}
                | (32'($urandom_range(3, 0)) << 9)
                | (32'(sets[$urandom_range(3, 0)]) << 3)
                | 32'($urandom_range(7, 0));
            d  = $urandom;
            wr = ($urandom_range(3, 0) == 0);
            access(wr, a, d, rd, low, rs, ws, sa, swd);
            if (wr) begin
                ref_write(a, d);
                n_cmp++; if (low !== 6) begin n_bad++; $display("FAIL rnd%0d wr ready_low: got %0d expected 6", i, low); end
                n_cmp++; if (ws !== 1'b1 || sa !== {a[18:2], 1'b0} || swd !== d) begin
                    n_bad++; $display("FAIL rnd%0d wr sram: got en=%b addr=%h data=%h expected en=1 addr=%h data=%h",
                                      i, ws, sa, swd, {a[18:2], 1'b0}, d);
                end
            end else begin
                ref_read(a, exp, h);
                want = h ? 0 : 6;
                n_cmp++; if (low !== want) begin n_bad++; $display("FAIL rnd%0d rd ready_low a=%h: got %0d expected %0d", i, a, low, want); end
                n_cmp++; if (rd !== exp)   begin n_bad++; $display("FAIL rnd%0d rd rdata a=%h: got %h expected %h", i, a, rd, exp); end
                n_cmp++; if (rs !== !h || (!h && sa !== {a[18:3], 2'b00})) begin
                    n_bad++; $display("FAIL rnd%0d rd sram: got en=%b addr=%h expected en=%b addr=%h", i, rs, sa, !h, {a[18:3], 2'b00});
                end
            end
            if ($urandom_range(3, 0) == 0) @(posedge clk);
        end
        check_counters("random");
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd, exp; int low; bit rs, ws, h; logic [17:0] sa; logic [31:0] swd;
        access(0, 32'h0000_0404, 32'h0, rd, low, rs, ws, sa, swd);
        ref_read(32'h0000_0404, exp, h);
        @(negedge clk);
        rd_en = 1; addr = 32'h0000_00A4;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++; if (sram_rd_en !== 1'b1) begin n_bad++; $display("FAIL midfill pre sram_rd_en: got %b expected 1", sram_rd_en); end
        rd_en = 0; rst = 1;
        #1;
        n_cmp++; if (ready !== 1'b1)      begin n_bad++; $display("FAIL midfill ready: got %b expected 1", ready); end
        n_cmp++; if (sram_rd_en !== 1'b0) begin n_bad++; $display("FAIL midfill sram_rd_en: got %b expected 0", sram_rd_en); end
        ref_reset();
        check_counters("midfill_reset");
        @(negedge clk);
        rst = 0;
        access(0, 32'h0000_00A4, 32'h0, rd, low, rs, ws, sa, swd);
        ref_read(32'h0000_00A4, exp, h);
        n_cmp++; if (low !== 6) begin n_bad++; $display("FAIL midfill reread ready_low: got %0d expected 6", low); end
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL midfill reread rdata: got %h expected %h", rd, exp); end
        access(0, 32'h0000_0404, 32'h0, rd, low, rs, ws, sa, swd);
        ref_read(32'h0000_0404, exp, h);
        n_cmp++; if (low !== 6) begin n_bad++; $display("FAIL midfill old_line ready_low: got %0d expected 6", low); end
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL midfill old_line rdata: got %h expected %h", rd, exp); end
        check_counters("midfill_after");
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            sram_mem[i] = init_line(i);
            ref_mem[i]  = init_line(i);
        end
        sram_mem[16'h80] = 64'h1111_2222_3333_4444;
        ref_mem[16'h80]  = 64'h1111_2222_3333_4444;
        test_reset();
        test_cold_fill();
        test_lru_evict();
        test_write_hit();
        test_write_miss();
        test_random();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- 2-way set-associative, write-through, read-allocate / no-write-allocate data cache between the MEM stage and sram_controller.
- Serves read hits in the request cycle; misses and all writes go to sram_controller (64-bit line fill, 32-bit write).
- Freezes the pipeline through `ready` while an SRAM transaction is in flight.

Parameters:
- SET_BITS, 6, log2 of set count (64 sets).
- TAG_W, 10, tag width; address bits [18:9] with defaults.
- SRAM_AW, 18, SRAM halfword address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rd_en  in  1  MEM-stage load request
- wr_en  in  1  MEM-stage store request
- addr  in  32  byte address; bits [1:0] are ignored
- wdata  in  32  store data
- rdata  out  32  load data; valid when rd_en and ready are both high
- ready  out  1  low freezes the pipeline
- sram_rd_en  out  1  line-fill request to sram_controller
- sram_wr_en  out  1  word-write request to sram_controller
- sram_addr  out  18  SRAM halfword address
- sram_wdata  out  32  write data to sram_controller
- sram_rdata  in  64  filled line; low word at [31:0]
- sram_ready  in  1  transaction done; combinationally high when sram_controller is idle

Behaviour:
- Reset (rst, asynchronous, active-high; clock clk):
  - state=IDLE; all valid bits=0; all LRU bits=0.
  - ready=1, sram_rd_en=0, sram_wr_en=0, sram_addr=0, sram_wdata=0, rdata=0.
- Address split: offset=addr[2] (word in line), index=addr[8:3], tag=addr[18:9].
- Per set: valid/tag/64-bit data for way0 and way1; one LRU bit, which names the least-recently-used way.
- Hit: valid[w] and tag[w]==tag; at most one way hits.
- FSM:
  - IDLE, wr_en: go to WRITE; ready=0 this cycle. wr_en has priority if rd_en is also high (illegal combination, defined anyway).
  - IDLE, rd_en and hit: rdata=hit way word[offset] combinationally; ready=1; LRU<=other way; stay in IDLE (0-cycle latency).
  - IDLE, rd_en and miss: go to FILL; ready=0.
  - IDLE, no request: ready=1; rdata=0.
  - FILL:
    - Drive sram_rd_en=1 and sram_addr={addr[18:3],2'b00}.
    - Hold until sram_ready=1. In that cycle:
      - Victim is the invalid way (way0 if both are invalid), otherwise the LRU way.
      - Victim data<=sram_rdata, tag<=tag, valid<=1; LRU<=other way.
      - rdata=sram_rdata word[offset]; ready=1; next state IDLE.
    - sram_rd_en drops the following cycle.
  - WRITE:
    - Drive sram_wr_en=1, sram_addr={addr[18:2],1'b0}, sram_wdata=wdata.
    - Hold until sram_ready=1. In that cycle:
      - On hit, the hit way word[offset]<=wdata and LRU<=other way.
      - On miss, cache state is unchanged.
      - ready=1; next state IDLE.
- Latency:
  - Read hit: 0 extra cycles.
  - Miss and write: 1 + SRAM latency; 6 cycles with the current sram_controller, so ready is low for 6 cycles.
- Upstream must hold addr/wdata/rd_en/wr_en stable while ready=0 (frozen stage).
- The enable must go low one cycle after sram_ready, so sram_controller counter wrap 5→0 lines up.
- Reset mid-FILL/WRITE: return to IDLE immediately; no partial line is installed; enables drop asynchronously.
- Same-set, different-tag sequences must evict per LRU. A third tag evicts the LRU way, never the MRU way.

Optional Feature:
- Macro CACHE_PERF_CNT_EN.
- Defined:
  - Adds ports hit_cnt out 32 and miss_cnt out 32; both reset to 0.
  - hit_cnt increments on each IDLE read hit; miss_cnt increments on each FILL completion.
  - Writes are not counted; counters wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg:
  - state enum {IDLE, FILL, WRITE}.
  - Constants LINE_W=64, WORD_W=32.
  - Localparams for index/tag/offset bit positions, derived from SET_BITS/TAG_W.
- Sub-module cache_array:
  - Holds valid/tag/data/LRU storage with async-reset valid and LRU.
  - Provides a combinational hit/way/word lookup and a single write port (fill line, or word update + LRU update).
- cache_controller holds the FSM, address muxing and handshake.

Test Plan:
- Cold read addr=0x0000_0404 with SRAM model holding line 0x1111_2222_3333_4444 → ready low 6 cycles; sram_addr=0x200; rdata=0x1111_2222; valid set in index 0.
- Repeat read 0x400 → ready=1 the same cycle; rdata=0x3333_4444; no sram_rd_en.
- Three tags to index 5: reads 0x428, 0xA28, 0x428, then 0x1028 → third fill evicts the way holding 0xA28; a re-read of 0x428 hits; 0xA28 misses.
- Write 0x0000_0404 data 0xDEAD_BEEF after fill → sram_wr_en with sram_addr=0x202; sram_wdata=0xDEADBEEF; subsequent read 0x404 hits with 0xDEADBEEF.
- Write miss to 0x8000 → SRAM write issued; read 0x8000 afterwards misses (no allocate).
- Assert rst at cycle 3 of a fill → state IDLE, ready=1, sram_rd_en=0; read of the same address misses again. With CACHE_PERF_CNT_EN: hit_cnt/miss_cnt match the hit/miss counts of the sequences above.
